// File: rtl/pill_schedule_monitor.sv
// pill_schedule_monitor
// Parametrised per-pill hourly dose countdown. Each channel reloads from its
// field of the schedule ROM word, counts down once per hour rollover of the
// real-time clock, and raises a due flag on expiry that is held until the
// patient acknowledges it.
//
// Optional build macro: MISSED_DOSE_EN
//   defined   -> per-channel saturating missed-dose counters are built.
//   undefined -> missed_count is tied to zero and no counter flops exist.
module pill_schedule_monitor #(
    parameter int NUM_PILLS = 3,
    parameter int DUR_W     = 4,
    parameter int RUN_STATE = 3,
    parameter int MISS_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  state,
    input  logic [NUM_PILLS*DUR_W-1:0]  rom_content,
    input  logic [23:0]                 bits_from_clock,
    input  logic [NUM_PILLS-1:0]        chan_enable,
    input  logic [NUM_PILLS-1:0]        pill_taken,
    output logic [NUM_PILLS*DUR_W-1:0]  pill_durations,
    output logic [NUM_PILLS-1:0]        pill_due,
    output logic                        any_due,
    output logic [NUM_PILLS*MISS_W-1:0] missed_count
);

    localparam logic [3:0] RUN_CODE = 4'(RUN_STATE);

    // Mode decode and hour-tick detection
    logic        w_load_mode;
    logic        w_run_mode;
    logic        w_hour_changed;
    logic        w_minsec_same;
    logic        w_tick;

    // Clock snapshot taken on load and on every tick
    logic [23:0] r_snapshot;

    // Codes 0..2 are the set-up states of the control FSM; they take
    // precedence even if RUN_STATE were configured into that range.
    assign w_load_mode    = (state <= 4'd2);
    assign w_run_mode     = (state == RUN_CODE) && !w_load_mode;

    // A tick is an hour-field change with the minute/second field untouched,
    // so a minute-only update never counts as an hour. Any inequality of the
    // hour field qualifies, including the 23 -> 0 wrap.
    assign w_hour_changed = (r_snapshot[23:16] != bits_from_clock[23:16]);
    assign w_minsec_same  = (r_snapshot[15:0]  == bits_from_clock[15:0]);
    assign w_tick         = w_run_mode && w_hour_changed && w_minsec_same;

    // Snapshot follows the clock in load mode and re-arms on each tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snapshot <= 24'd0;
        end else if (w_load_mode) begin
            r_snapshot <= bits_from_clock;
        end else if (w_tick) begin
            r_snapshot <= bits_from_clock;
        end
    end

    // Per-channel countdown, due flag and optional missed-dose counter
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PILLS; gi++) begin : g_chan
            logic [DUR_W-1:0] w_rom_field;
            logic             w_enabled_run;
            logic             w_expire;
            logic [DUR_W-1:0] r_dur;
            logic             r_due;

            assign w_rom_field   = rom_content[gi*DUR_W +: DUR_W];
            assign w_enabled_run = w_run_mode && chan_enable[gi];

            // Expiry: an enabled channel already at zero when the tick lands.
            // A ROM field of zero therefore expires on every tick.
            assign w_expire      = w_tick && chan_enable[gi] && (r_dur == '0);

            // Countdown/due update; set-on-expiry beats a same-cycle acknowledge
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_dur <= '0;
                    r_due <= 1'b0;
                end else if (w_load_mode) begin
                    r_dur <= w_rom_field;
                    r_due <= 1'b0;
                end else if (w_run_mode && !chan_enable[gi]) begin
                    // Disabled channel shadows its ROM field and is never due
                    r_dur <= w_rom_field;
                    r_due <= 1'b0;
                end else if (w_expire) begin
                    r_dur <= w_rom_field;
                    r_due <= 1'b1;
                end else begin
                    // Enabled, not expiring: count down on a tick (value is
                    // known non-zero here, so no wrap is possible)
                    if (w_tick && w_enabled_run) begin
                        r_dur <= r_dur - DUR_W'(1);
                    end
                    // Acknowledge is honoured in run mode and in idle codes;
                    // when not due the clear is a no-op.
                    if (pill_taken[gi]) begin
                        r_due <= 1'b0;
                    end
                end
            end

            assign pill_durations[gi*DUR_W +: DUR_W] = r_dur;
            assign pill_due[gi]                      = r_due;

`ifdef MISSED_DOSE_EN
            logic              w_miss_evt;
            logic [MISS_W-1:0] r_missed;

            // A miss is a fresh expiry landing on an unacknowledged flag;
            // an acknowledge in the same cycle retires the old dose.
            assign w_miss_evt = w_expire && r_due && !pill_taken[gi];

            // Saturating missed-dose counter, cleared only by reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_missed <= '0;
                end else if (w_miss_evt && (r_missed != '1)) begin
                    r_missed <= r_missed + MISS_W'(1);
                end
            end

            assign missed_count[gi*MISS_W +: MISS_W] = r_missed;
`else
            assign missed_count[gi*MISS_W +: MISS_W] = '0;
`endif
        end
    endgenerate

    // Summary flag for the control FSM, same cycle as the per-pill flags
    assign any_due = |pill_due;

endmodule

// File: tb/tb_pill_schedule_monitor.sv
// Self-checking bench for pill_schedule_monitor: directed scenarios with
// literal expectations, followed by randomized traffic, all compared every
// cycle against a behavioural model of the dose schedule.
module tb_pill_schedule_monitor;

    localparam int NP  = 3;
    localparam int DW  = 4;
    localparam int RUN = 3;
    localparam int MW  = 4;
`ifdef MISSED_DOSE_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [3:0]        state;
    logic [NP*DW-1:0]  rom_content;
    logic [23:0]       bits_from_clock;
    logic [NP-1:0]     chan_enable;
    logic [NP-1:0]     pill_taken;
    logic [NP*DW-1:0]  pill_durations;
    logic [NP-1:0]     pill_due;
    logic              any_due;
    logic [NP*MW-1:0]  missed_count;

    pill_schedule_monitor #(
        .NUM_PILLS (NP),
        .DUR_W     (DW),
        .RUN_STATE (RUN),
        .MISS_W    (MW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .state           (state),
        .rom_content     (rom_content),
        .bits_from_clock (bits_from_clock),
        .chan_enable     (chan_enable),
        .pill_taken      (pill_taken),
        .pill_durations  (pill_durations),
        .pill_due        (pill_due),
        .any_due         (any_due),
        .missed_count    (missed_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int          m_dur  [NP];
    bit          m_due  [NP];
    int          m_miss [NP];
    logic [23:0] m_snap;
    int          hr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_update();
        bit tick;
        int rom_f;
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                m_dur[i] = 0; m_due[i] = 0; m_miss[i] = 0;
            end
            m_snap = 24'd0;
        end else if (state <= 4'd2) begin
            for (int i = 0; i < NP; i++) begin
                m_dur[i] = int'(rom_content[i*DW +: DW]);
                m_due[i] = 0;
            end
            m_snap = bits_from_clock;
        end else if (state == 4'(RUN)) begin
            tick = (m_snap[23:16] != bits_from_clock[23:16]) &&
                   (m_snap[15:0]  == bits_from_clock[15:0]);
            for (int i = 0; i < NP; i++) begin
                rom_f = int'(rom_content[i*DW +: DW]);
                if (!chan_enable[i]) begin
                    m_dur[i] = rom_f;
                    m_due[i] = 0;
                end else if (tick && m_dur[i] == 0) begin
                    if (MISS_EN && m_due[i] && !pill_taken[i] && m_miss[i] < (1 << MW) - 1)
                        m_miss[i]++;
                    m_dur[i] = rom_f;
                    m_due[i] = 1;
                end else begin
                    if (tick) m_dur[i]--;
                    if (pill_taken[i]) m_due[i] = 0;
                end
            end
            if (tick) m_snap = bits_from_clock;
        end else begin
            for (int i = 0; i < NP; i++)
                if (pill_taken[i]) m_due[i] = 0;
        end
    endtask

    // Compare every DUT output against the model
    task automatic check_model();
        logic [NP*DW-1:0] e_dur;
        logic [NP-1:0]    e_due;
        logic [NP*MW-1:0] e_miss;
        for (int i = 0; i < NP; i++) begin
            e_dur[i*DW +: DW]  = DW'(m_dur[i]);
            e_due[i]           = m_due[i];
            e_miss[i*MW +: MW] = MW'(m_miss[i]);
        end
        check("durations", 32'(pill_durations), 32'(e_dur));
        check("due",       32'(pill_due),       32'(e_due));
        check("any_due",   32'(any_due),        32'(|e_due));
        check("missed",    32'(missed_count),   32'(e_miss));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic tick_once();
        hr = (hr + 1) % 24;
        bits_from_clock = {8'(hr), 16'h1234};
        step();
    endtask

    initial begin
        rst_n = 1'b0; state = 4'd0; rom_content = '0; bits_from_clock = '0;
        chan_enable = 3'b111; pill_taken = '0; m_snap = '0; hr = 0;
        for (int i = 0; i < NP; i++) begin m_dur[i] = 0; m_due[i] = 0; m_miss[i] = 0; end

        // Reset state
        step();
        check("rst_dur", 32'(pill_durations), 32'h0);
        check("rst_due", 32'(pill_due), 32'h0);
        check("rst_any", 32'(any_due), 32'h0);
        check("rst_miss", 32'(missed_count), 32'h0);

        // Load
        rst_n = 1'b1; rom_content = 12'h532; bits_from_clock = 24'h09_1234;
        step();
        check("load_dur", 32'(pill_durations), 32'h532);
        check("load_due", 32'(pill_due), 32'h0);

        // Countdown, minute-only change ignored
        state = 4'd3;
        bits_from_clock = 24'h0A_1234; step();
        check("tick1_dur", 32'(pill_durations), 32'h421);
        bits_from_clock = 24'h0B_1234; step();
        check("tick2_dur", 32'(pill_durations), 32'h310);
        bits_from_clock = 24'h0B_1300; step();
        check("minute_only", 32'(pill_durations), 32'h310);
        bits_from_clock = 24'h0C_1234; step();
        check("expire_dur", 32'(pill_durations), 32'h202);
        check("expire_due", 32'(pill_due), 32'h1);
        check("expire_any", 32'(any_due), 32'h1);
        pill_taken = 3'b001; step(); pill_taken = '0;
        check("ack_due", 32'(pill_due), 32'h0);

        // Channel 1 disabled across five ticks
        state = 4'd0; rom_content = 12'h532; bits_from_clock = 24'h09_1234;
        chan_enable = 3'b101; step();
        state = 4'd3; hr = 9;
        for (int k = 0; k < 5; k++) tick_once();
        check("en101_dur", 32'(pill_durations), 32'h030);
        check("en101_due", 32'(pill_due), 32'h1);

        // Mid-run reset with a due flag set
        rst_n = 1'b0; hr = hr + 1; bits_from_clock = {8'(hr), 16'h1234}; step();
        check("midrst_dur", 32'(pill_durations), 32'h0);
        check("midrst_due", 32'(pill_due), 32'h0);
        check("midrst_any", 32'(any_due), 32'h0);
        rst_n = 1'b1; chan_enable = 3'b111;

        // Hour change in an idle state code does nothing
        state = 4'd0; rom_content = 12'h532; bits_from_clock = 24'h09_1234; step();
        state = 4'd5; bits_from_clock = 24'h0A_1234; step();
        check("idle_hold", 32'(pill_durations), 32'h532);

        // ROM field 0: due every tick; same-cycle ack, then misses to saturation
        state = 4'd0; rom_content = 12'h530; bits_from_clock = 24'h11_1234; step();
        state = 4'd3; hr = 17;
        tick_once();
        check("zero_rom_due", 32'(pill_due[0]), 32'h1);
        pill_taken = 3'b001; tick_once(); pill_taken = '0;
        check("same_cyc_due", 32'(pill_due[0]), 32'h1);
        check("same_cyc_miss", 32'(missed_count[MW-1:0]), 32'h0);
        tick_once();
        check("first_miss", 32'(missed_count[MW-1:0]), MISS_EN ? 32'd1 : 32'd0);
        for (int k = 0; k < 20; k++) tick_once();
        check("miss_sat", 32'(missed_count[MW-1:0]), MISS_EN ? 32'd15 : 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 15);
            if (r < 2)       state = 4'($urandom_range(0, 2));
            else if (r < 13) state = 4'(RUN);
            else             state = 4'($urandom_range(4, 15));
            if ($urandom_range(0, 19) == 0) rom_content = 12'($urandom);
            if ($urandom_range(0, 9) == 0)  chan_enable = 3'($urandom);
            else if ($urandom_range(0, 9) == 0) chan_enable = 3'b111;
            pill_taken = 3'($urandom) & 3'($urandom);
            r = $urandom_range(0, 3);
            if (r < 2)       bits_from_clock = {8'($urandom_range(0, 23)), m_snap[15:0]};
            else if (r == 2) bits_from_clock = m_snap;
            else             bits_from_clock = 24'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pill_schedule_monitor.md
Name: pill_schedule_monitor

Overview:
- Parametrised successor to the three-pill next-dose countdown.
- Tracks NUM_PILLS independent hourly countdowns loaded from the schedule ROM word, decremented on each hour rollover of the real-time clock bits.
- Raises a per-pill due flag at expiry; the flag is held until the patient-acknowledge pulse clears it.
- Sits between the schedule ROM / clock block and the control FSM / display driver.

Parameters:
- NUM_PILLS, 3, number of pill channels.
- DUR_W, 4, width of each duration field in hours.
- RUN_STATE, 3, control-FSM state code in which countdown runs.
- MISS_W, 4, width of the per-channel missed-dose counter (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- state  in  4  control-FSM state code.
- rom_content  in  NUM_PILLS*DUR_W  packed reload durations; channel i at [i*DUR_W +: DUR_W].
- bits_from_clock  in  24  clock time; [23:16] hours, [15:0] minutes/seconds.
- chan_enable  in  NUM_PILLS  per-channel enable.
- pill_taken  in  NUM_PILLS  per-channel acknowledge pulse.
- pill_durations  out  NUM_PILLS*DUR_W  packed remaining hours, same packing as rom_content.
- pill_due  out  NUM_PILLS  per-channel dose-due flag.
- any_due  out  1  OR-reduction of pill_due.
- missed_count  out  NUM_PILLS*MISS_W  packed missed-dose counters.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset values: all durations 0, pill_due 0, any_due 0, missed_count 0, clock snapshot 0.
- Load mode (state 0, 1 or 2):
  - Every cycle, all durations load from rom_content.
  - Snapshot register loads bits_from_clock.
  - pill_due clears.
  - missed_count holds.
- Run mode (state == RUN_STATE): hour tick is asserted in a cycle when both hold:
  - snapshot[23:16] != bits_from_clock[23:16], and
  - snapshot[15:0] == bits_from_clock[15:0].
  On a tick the snapshot loads bits_from_clock. Ticks are not possible outside run mode.
- Per enabled channel, on a tick:
  - Duration 0: reload the ROM field and set pill_due.
  - Otherwise: decrement by 1.
  - No wrap below 0.
- Disabled channel (chan_enable[i] = 0), in run mode: duration is forced to the ROM field; pill_due is forced 0; no missed events.
- A ROM field of 0 makes the channel due on every tick.
- Any other state code: all registers hold; pill_taken is still honoured.
- Acknowledge: pill_taken[i] while pill_due[i] = 1 clears the flag on the next edge. pill_taken while not due is ignored.
- Same-cycle tick-set and taken on one channel: set wins; the flag stays 1 and the old dose counts as acknowledged (not missed).
- Latency: all outputs are registered.
  - Duration and due change on the clock edge that samples the tick.
  - any_due follows pill_due combinationally, with no additional cycle.
- Reset mid-run: takes priority over every other input; all state returns to reset values on that edge.
- Rollover 23->0 on the hour field counts as a normal tick; only inequality is checked.

Optional Feature:
- MISSED_DOSE_EN defined:
  - On a tick that sets pill_due[i] while pill_due[i] is already 1 and pill_taken[i] = 0 that cycle, missed_count[i] increments.
  - The counter saturates at 2^MISS_W-1.
  - Counters clear only on reset.
- MISSED_DOSE_EN undefined: missed_count is driven constant 0 and no counter flops are built.

Test Plan:
- Reset, then state=0 with rom_content=12'h532, bits 24'h09_1234 -> next cycle pill_durations=12'h532, pill_due=0, snapshot=24'h09_1234.
- Run state, bits step 24'h0A_1234, then 24'h0B_1234 -> durations 12'h421, then 12'h310; a minute-only change to 24'h0B_1300 produces no decrement.
- Channel 0 (ROM 2) reaches 0; next tick -> duration reloads 2, pill_due[0]=1, any_due=1; pill_taken[0] pulse -> pill_due[0]=0 one edge later.
- Tick and pill_taken[0] in same cycle while due -> pill_due[0] stays 1, missed_count[0] unchanged; with MISSED_DOSE_EN, a further expiry without acknowledge -> missed_count[0]=1; 20 misses with MISS_W=4 -> saturates at 15.
- chan_enable=3'b101 across 5 ticks -> channel 1 holds its ROM value with due 0; channels 0 and 2 count normally.
- rst_n low for one cycle mid-run with due flags set -> all outputs 0 on that edge; hour change with state=5 -> no decrement.
